// File: rtl/tlb_refill_walker_pkg.sv
// Shared geometry, PTE field layout and FSM encodings for the TLB refill walker.
package tlb_refill_walker_pkg;

  localparam int DEFAULT_NUM_WAYS       = 4;
  localparam int DEFAULT_SET_INDEX_BITS = 4;

  localparam int VPN_BITS   = 20;
  localparam int PPN_BITS   = 20;
  localparam int VPN_L1_LSB = 10;
  localparam int VPN_L0_BITS = 10;

  localparam int PTE_V        = 0;
  localparam int PTE_PERM_LSB = 1;
  localparam int PTE_PPN_LSB  = 12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_L1_REQ  = 3'd1;
  localparam logic [2:0] ST_L1_WAIT = 3'd2;
  localparam logic [2:0] ST_L2_REQ  = 3'd3;
  localparam logic [2:0] ST_L2_WAIT = 3'd4;
  localparam logic [2:0] ST_FILL    = 3'd5;
  localparam logic [2:0] ST_FAULT   = 3'd6;
  localparam logic [2:0] ST_DRAIN   = 3'd7;

  typedef struct packed {
    logic [PPN_BITS-1:0] ppn;
    logic [1:0]          perms;
    logic                valid;
  } pte_t;

  function automatic pte_t decode_pte(input logic [31:0] raw);
    pte_t p;
    p.ppn   = raw[PTE_PPN_LSB +: PPN_BITS];
    p.perms = raw[PTE_PERM_LSB +: 2];
    p.valid = raw[PTE_V];
    return p;
  endfunction

endpackage

// File: rtl/tlb_refill_walker_repl_rr.sv
// Victim-way selection for TLB refills: lowest invalid way first, otherwise a
// per-set round-robin pointer that only moves when a fill actually consumed it.
module tlb_repl_rr
  import tlb_refill_walker_pkg::*;
#(
  parameter int NUM_WAYS       = DEFAULT_NUM_WAYS,
  parameter int SET_INDEX_BITS = DEFAULT_SET_INDEX_BITS,
  localparam int WAY_BITS      = $clog2(NUM_WAYS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [SET_INDEX_BITS-1:0] i_set,
  input  logic [NUM_WAYS-1:0]       i_set_valid,
  input  logic                      i_advance,
  input  logic                      i_flush,
  output logic [WAY_BITS-1:0]       o_way
);

  localparam int NUM_SETS = 1 << SET_INDEX_BITS;

  logic [WAY_BITS-1:0] r_ptr [NUM_SETS];
  logic                w_all_valid;
  logic [WAY_BITS-1:0] w_first_invalid;
  logic [WAY_BITS-1:0] w_cur_ptr;

  always_comb begin
    w_first_invalid = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!i_set_valid[w]) begin
        w_first_invalid = WAY_BITS'(w);
      end
    end
  end

  assign w_all_valid = &i_set_valid;
  assign w_cur_ptr   = r_ptr[i_set];
  assign o_way       = w_all_valid ? w_cur_ptr : w_first_invalid;

  // Explicit wrap keeps the pointer legal for non-power-of-two associativity.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (i_advance && w_all_valid) begin
      if (w_cur_ptr == WAY_BITS'(NUM_WAYS - 1)) begin
        r_ptr[i_set] <= '0;
      end else begin
        r_ptr[i_set] <= w_cur_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_refill_walker.sv
// TLB miss handler: two-level page-table walk over a memory read port, then a
// one-cycle refill into the addressed set, or a page-fault report.
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
#(
  parameter int NUM_WAYS       = DEFAULT_NUM_WAYS,
  parameter int SET_INDEX_BITS = DEFAULT_SET_INDEX_BITS,
  localparam int WAY_BITS      = $clog2(NUM_WAYS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_miss_valid,
  input  logic [VPN_BITS-1:0]       i_miss_vpn,
  output logic                      o_miss_ready,
  input  logic [PPN_BITS-1:0]       i_ptbr,
  input  logic [NUM_WAYS-1:0]       i_set_valid,
  output logic                      o_mem_req_valid,
  output logic [31:0]               o_mem_req_addr,
  input  logic                      i_mem_req_ready,
  input  logic                      i_mem_resp_valid,
  input  logic [31:0]               i_mem_resp_data,
  output logic                      o_fill_en,
  output logic [SET_INDEX_BITS-1:0] o_fill_set,
  output logic [WAY_BITS-1:0]       o_fill_way,
  output logic [VPN_BITS-1:0]       o_fill_vpn,
  output logic [PPN_BITS-1:0]       o_fill_ppn,
  output logic [1:0]                o_fill_perms,
  output logic                      o_walk_done,
  output logic                      o_walk_fault,
  input  logic                      i_flush
);

  logic [2:0]                r_state;
  logic [VPN_BITS-1:0]       r_vpn;
  logic [PPN_BITS-1:0]       r_leaf_ppn;
  logic [1:0]                r_leaf_perms;
  logic                      r_mem_req_valid;
  logic [31:0]               r_mem_req_addr;
  logic                      r_fill_en;
  logic [SET_INDEX_BITS-1:0] r_fill_set;
  logic [WAY_BITS-1:0]       r_fill_way;
  logic [VPN_BITS-1:0]       r_fill_vpn;
  logic [PPN_BITS-1:0]       r_fill_ppn;
  logic [1:0]                r_fill_perms;
  logic                      r_walk_done;
  logic                      r_walk_fault;

  pte_t                      w_pte;
  logic [WAY_BITS-1:0]       w_victim;
  logic                      w_advance;
  logic                      w_unused_pte_bits;

  assign w_pte             = decode_pte(i_mem_resp_data);
  assign w_unused_pte_bits = ^i_mem_resp_data[PTE_PPN_LSB-1:PTE_PERM_LSB+2];
  assign w_advance         = (r_state == ST_FILL) && !i_flush;

  tlb_repl_rr #(
    .NUM_WAYS       (NUM_WAYS),
    .SET_INDEX_BITS (SET_INDEX_BITS)
  ) u_repl (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_set       (r_vpn[SET_INDEX_BITS-1:0]),
    .i_set_valid (i_set_valid),
    .i_advance   (w_advance),
    .i_flush     (i_flush),
    .o_way       (w_victim)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_vpn           <= '0;
      r_leaf_ppn      <= '0;
      r_leaf_perms    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_fill_en       <= 1'b0;
      r_fill_set      <= '0;
      r_fill_way      <= '0;
      r_fill_vpn      <= '0;
      r_fill_ppn      <= '0;
      r_fill_perms    <= '0;
      r_walk_done     <= 1'b0;
      r_walk_fault    <= 1'b0;
    end else begin
      r_fill_en    <= 1'b0;
      r_walk_done  <= 1'b0;
      r_walk_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_miss_valid && !i_flush) begin
            r_vpn           <= i_miss_vpn;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {i_ptbr, i_miss_vpn[VPN_BITS-1:VPN_L1_LSB], 2'b00};
            r_state         <= ST_L1_REQ;
          end
        end
        ST_L1_REQ, ST_L2_REQ: begin
          if (i_flush) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= ST_IDLE;
          end else if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= (r_state == ST_L1_REQ) ? ST_L1_WAIT : ST_L2_WAIT;
          end
        end
        ST_L1_WAIT: begin
          // A response landing in the flush cycle is already consumed, so no drain.
          if (i_flush) begin
            r_state <= i_mem_resp_valid ? ST_IDLE : ST_DRAIN;
          end else if (i_mem_resp_valid) begin
            if (!w_pte.valid) begin
              r_state <= ST_FAULT;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= {w_pte.ppn, r_vpn[VPN_L0_BITS-1:0], 2'b00};
              r_state         <= ST_L2_REQ;
            end
          end
        end
        ST_L2_WAIT: begin
          if (i_flush) begin
            r_state <= i_mem_resp_valid ? ST_IDLE : ST_DRAIN;
          end else if (i_mem_resp_valid) begin
            if (!w_pte.valid) begin
              r_state <= ST_FAULT;
            end else begin
              r_leaf_ppn   <= w_pte.ppn;
              r_leaf_perms <= w_pte.perms;
              r_state      <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (!i_flush) begin
            r_fill_en    <= 1'b1;
            r_walk_done  <= 1'b1;
            r_fill_set   <= r_vpn[SET_INDEX_BITS-1:0];
            r_fill_way   <= w_victim;
            r_fill_vpn   <= r_vpn;
            r_fill_ppn   <= r_leaf_ppn;
            r_fill_perms <= r_leaf_perms;
          end
          r_state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (!i_flush) begin
            r_walk_done  <= 1'b1;
            r_walk_fault <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (i_mem_resp_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_miss_ready    = (r_state == ST_IDLE);
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_addr  = r_mem_req_addr;
  assign o_fill_en       = r_fill_en;
  assign o_fill_set      = r_fill_set;
  assign o_fill_way      = r_fill_way;
  assign o_fill_vpn      = r_fill_vpn;
  assign o_fill_ppn      = r_fill_ppn;
  assign o_fill_perms    = r_fill_perms;
  assign o_walk_done     = r_walk_done;
  assign o_walk_fault    = r_walk_fault;

endmodule
